core_data_router: RTL



---
 rtl/core_data_router.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/core_data_router.sv
// core_data_router: round-robin data interconnect with address decode and in-order response routing.
// Optional DATA_ROUTER_ERR_RESP_EN enables an internal decode-error responder.
module core_data_router #(
    parameter int N_INITIATORS = 2,
    parameter int N_TARGETS = 2,
    parameter int OUTSTANDING_DEPTH = 2,
    parameter logic [N_TARGETS*32-1:0] TARGET_BASE = {32'h2000_0000, 32'h0000_0000},
    parameter logic [N_TARGETS*32-1:0] TARGET_MASK = {32'hF000_0000, 32'hFFFF_E000}
) (
    input  logic                      clk_i,
    input  logic                      reset_i,
    input  logic [N_INITIATORS-1:0]   init_req_i,
    output logic [N_INITIATORS-1:0]   init_gnt_o,
    input  logic [N_INITIATORS*32-1:0] init_addr_i,
    input  logic [N_INITIATORS-1:0]   init_we_i,
    input  logic [N_INITIATORS*4-1:0] init_be_i,
    input  logic [N_INITIATORS*32-1:0] init_wdata_i,
    output logic [N_INITIATORS-1:0]   init_rvalid_o,
    output logic [N_INITIATORS*32-1:0] init_rdata_o,
    output logic [N_INITIATORS-1:0]   init_err_o,
    output logic [N_TARGETS-1:0]      tgt_req_o,
    input  logic [N_TARGETS-1:0]      tgt_gnt_i,
    output logic [31:0]               tgt_addr_o,
    output logic                      tgt_we_o,
    output logic [3:0]                tgt_be_o,
    output logic [31:0]               tgt_wdata_o,
    input  logic [N_TARGETS-1:0]      tgt_rvalid_i,
    input  logic [N_TARGETS*32-1:0]   tgt_rdata_i,
    input  logic [N_TARGETS-1:0]      tgt_err_i
);
    localparam int NI = N_INITIATORS;
    localparam int IW = N_INITIATORS > 1 ? $clog2(N_INITIATORS) : 1;
    localparam int SW = IW + 1;
    localparam int TW = $clog2(N_TARGETS + 1);
    localparam int AW = $clog2(OUTSTANDING_DEPTH);
    localparam int PW = AW + 1;
    localparam int XW = AW > 0 ? AW : 1;

    typedef struct packed {
        logic [IW-1:0] init;
        logic [TW-1:0] tgt;
        logic          err;
    } entry_t;

    entry_t fifo [OUTSTANDING_DEPTH];
    entry_t head;
    entry_t youngest;
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [XW-1:0] wr_idx, rd_idx, yg_idx;
    logic full, empty;
    logic [IW-1:0] rr_ptr, off, win, nxt;
    logic [SW-1:0] sum;
    logic [NI-1:0] rot;
    logic [2*NI-1:0] dbl;
    logic win_valid;
    logic [31:0] w_addr, w_wdata;
    logic w_we;
    logic [3:0] w_be;
    logic hit, miss, go, granted;
    logic [TW-1:0] dec, tgt_sel;
    logic sel_rv, sel_er, rsp;
    logic [31:0] sel_rd;

    assign wr_idx = XW'(wr_ptr % PW'(OUTSTANDING_DEPTH));
    assign rd_idx = XW'(rd_ptr % PW'(OUTSTANDING_DEPTH));
    assign yg_idx = XW'(PW'(wr_ptr - PW'(1)) % PW'(OUTSTANDING_DEPTH));
    assign empty = wr_ptr == rd_ptr;
    assign full = PW'(wr_ptr - rd_ptr) == PW'(OUTSTANDING_DEPTH);
    assign head = fifo[rd_idx];
    assign youngest = fifo[yg_idx];

    // Rotate requests so the search always starts at the priority pointer.
    always_comb begin
        dbl = {init_req_i, init_req_i};
        rot = NI'(dbl >> rr_ptr);
        off = '0;
        for (int i = NI - 1; i >= 0; i--)
            if (rot[i]) off = IW'(i);
        sum = {1'b0, rr_ptr} + {1'b0, off};
        win = sum >= SW'(NI) ? IW'(sum - SW'(NI)) : IW'(sum);
        nxt = win == IW'(NI - 1) ? '0 : IW'(win + 1'b1);
        win_valid = |init_req_i & !reset_i;
    end

    always_comb begin
        w_addr = '0;
        w_wdata = '0;
        w_we = 1'b0;
        w_be = '0;
        for (int i = 0; i < NI; i++)
            if (win == IW'(i)) begin
                w_addr = init_addr_i[i*32 +: 32];
                w_wdata = init_wdata_i[i*32 +: 32];
                w_we = init_we_i[i];
                w_be = init_be_i[i*4 +: 4];
            end
    end

    // Lowest-index matching target wins.
    always_comb begin
        hit = 1'b0;
        dec = '0;
        for (int t = N_TARGETS - 1; t >= 0; t--)
            if ((w_addr & TARGET_MASK[t*32 +: 32]) == TARGET_BASE[t*32 +: 32]) begin
                hit = 1'b1;
                dec = TW'(t);
            end
    end

`ifdef DATA_ROUTER_ERR_RESP_EN
    // The error responder occupies pseudo-target index N_TARGETS for ordering.
    assign miss = !hit;
    assign tgt_sel = hit ? dec : TW'(N_TARGETS);
`else
    assign miss = 1'b0;
    assign tgt_sel = hit ? dec : TW'(N_TARGETS - 1);
`endif

    assign go = win_valid & !full & (empty | (tgt_sel == youngest.tgt));

    always_comb begin
        tgt_req_o = '0;
        for (int t = 0; t < N_TARGETS; t++)
            tgt_req_o[t] = go & (tgt_sel == TW'(t));
        granted = go & (miss | (|(tgt_req_o & tgt_gnt_i)));
        init_gnt_o = '0;
        for (int i = 0; i < NI; i++)
            init_gnt_o[i] = granted & (win == IW'(i));
        tgt_addr_o = |tgt_req_o ? w_addr : '0;
        tgt_we_o = |tgt_req_o ? w_we : 1'b0;
        tgt_be_o = |tgt_req_o ? w_be : '0;
        tgt_wdata_o = |tgt_req_o ? w_wdata : '0;
    end

    // Responses are only accepted from the target owning the FIFO head.
    always_comb begin
        sel_rv = 1'b0;
        sel_er = 1'b0;
        sel_rd = '0;
        for (int t = 0; t < N_TARGETS; t++)
            if (head.tgt == TW'(t)) begin
                sel_rv = tgt_rvalid_i[t];
                sel_er = tgt_err_i[t];
                sel_rd = tgt_rdata_i[t*32 +: 32];
            end
        rsp = !reset_i & !empty & (head.err | sel_rv);
        init_rvalid_o = '0;
        init_err_o = '0;
        init_rdata_o = '0;
        for (int i = 0; i < NI; i++)
            if (rsp && head.init == IW'(i)) begin
                init_rvalid_o[i] = 1'b1;
                init_err_o[i] = head.err | sel_er;
                init_rdata_o[i*32 +: 32] = head.err ? 32'h0 : sel_rd;
            end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            rr_ptr <= '0;
        end else begin
            if (granted) begin
                wr_ptr <= wr_ptr + 1'b1;
                rr_ptr <= nxt;
            end
            if (rsp) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_i && granted) fifo[wr_idx] <= '{init: win, tgt: tgt_sel, err: miss};
    end
endmodule
